// File: rtl/pol_mem_sweeper_if.sv
// pol_mem_sweeper_if: memory-side and result-stream signals of the polynomial memory sweeper.
interface pol_mem_sweeper_if #(
   parameter int AW = 4,
   parameter int DW = 9
);
   logic          mode;
   logic [AW-1:0] memAddr;
   logic          memOp;
   logic [1:0]    memArg;
   logic [DW-1:0] memData;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] rd_addr;
   modport master (
      output mode, memAddr, memOp, memArg, rd_valid, rd_data, rd_addr,
      input  memData, rd_ready
   );
   modport slave (
      input  mode, memAddr, memOp, memArg, rd_valid, rd_data, rd_addr,
      output memData, rd_ready
   );
endinterface

// File: rtl/pol_mem_sweeper.sv
// pol_mem_sweeper: writes every polynomial memory entry, reads each back and streams it out.
// Define POL_MEM_SWEEPER_SUM_EN to add the signed running sum of streamed results.
module pol_mem_sweeper #(
   parameter int AW     = 4,
   parameter int DW     = 9,
   parameter int RD_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic             op,
   input  logic [1:0]       arg,
   output logic             busy,
   output logic             done,
   pol_mem_sweeper_if.master bus
`ifdef POL_MEM_SWEEPER_SUM_EN
   , output logic signed [DW+AW-1:0] sum
`endif
);
   typedef enum logic [2:0] {IDLE, WRITE, RADDR, RWAIT, OUT, FIN} state_t;
   localparam logic [AW-1:0] LAST = '1;
   state_t     state, state_nx;
   logic [1:0] cnt;
   logic       hs;
   assign hs   = bus.rd_valid & bus.rd_ready;
   assign busy = state != IDLE;
   assign done = state == FIN;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = WRITE;
         WRITE:   if (bus.memAddr == LAST) state_nx = RADDR;
         RADDR:   state_nx = RWAIT;
         RWAIT:   if (cnt == '0) state_nx = OUT;
         OUT:     if (hs) state_nx = (bus.rd_addr == LAST) ? FIN : RADDR;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // the address is reloaded explicitly so a write can never follow an overflow
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         bus.mode     <= 1'b0;
         bus.memAddr  <= '0;
         bus.memOp    <= 1'b0;
         bus.memArg   <= 2'b00;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         bus.rd_addr  <= '0;
         cnt          <= 2'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bus.memOp   <= op;
               bus.memArg  <= arg;
               bus.memAddr <= '0;
               bus.mode    <= 1'b1;
            end
            WRITE: begin
               bus.memAddr <= (bus.memAddr == LAST) ? '0 : bus.memAddr + AW'(1);
               bus.mode    <= bus.memAddr != LAST;
            end
            RADDR: cnt <= 2'(RD_LAT - 1);
            RWAIT: if (cnt == '0) begin
               bus.rd_data  <= bus.memData;
               bus.rd_addr  <= bus.memAddr;
               bus.rd_valid <= 1'b1;
            end else cnt <= cnt - 2'd1;
            OUT: if (hs) begin
               bus.rd_valid <= 1'b0;
               if (bus.rd_addr != LAST) bus.memAddr <= bus.memAddr + AW'(1);
            end
            default: ;
         endcase
      end
`ifdef POL_MEM_SWEEPER_SUM_EN
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N)                     sum <= '0;
      else if (state == IDLE && start) sum <= '0;
      else if (hs)                     sum <= sum + {{AW{bus.rd_data[DW-1]}}, bus.rd_data};
`endif
endmodule

// File: doc/pol_mem_sweeper.md
Name: pol_mem_sweeper

Overview:
- Initiator-side controller for the polynomial memory (16 entries × 9-bit results; write mode evaluates the ROM coefficients at a chosen argument and stores the result).
- On `start`:
  1. Sweeps all addresses in write mode with a latched op/arg.
  2. Sweeps them again in read mode.
  3. Streams each read result to a downstream consumer over a valid/ready handshake.
- Replaces hand-driven mode/address sequencing in lab benches and the top level.

Parameters:
- AW, 4, memory address width; sweep covers 2**AW entries.
- DW, 9, memory data width; two's-complement signed.
- RD_LAT, 1, cycles from read-address presentation to valid `memData`; legal range 1..3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE.
- op  in  1  0: polynomial, 1: derivative; latched on accepted `start`.
- arg  in  2  00: +1, 01: +2, 10: −1, 11: −2; latched on accepted `start`.
- mode  out  1  to memory; 0 = read, 1 = write.
- memAddr  out  AW  to memory.
- memOp  out  1  latched `op`.
- memArg  out  2  latched `arg`.
- memData  in  DW  read data from memory.
- rd_valid  out  1  `rd_data` / `rd_addr` valid.
- rd_ready  in  1  consumer accepts when `rd_valid && rd_ready`.
- rd_data  out  DW  captured memory result.
- rd_addr  out  AW  address of `rd_data`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last entry is accepted.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE.
  - Outputs cleared: mode=0, memAddr=0, memOp=0, memArg=0, rd_valid=0, rd_data=0, rd_addr=0, busy=0, done=0.
  - Reset mid-sweep abandons the sweep. No partial `done` is produced. Memory contents are not restored.
- IDLE:
  - `start=1` latches op/arg into memOp/memArg, sets memAddr=0, mode=1, busy=1, and moves to WRITE.
  - `start` is ignored in all other states.
- WRITE:
  - One memory write per cycle; mode=1.
  - memAddr increments each cycle from 0 to 2**AW−1; exactly 2**AW write edges.
  - At the last address the next state is RADDR: mode=0, memAddr=0.
- RADDR: presents memAddr with mode=0; a counter loads RD_LAT−1 and the FSM moves to RWAIT.
- RWAIT: counts down. At zero, memData is captured into rd_data and memAddr into rd_addr; rd_valid=1; go to OUT.
- OUT:
  - rd_valid, rd_data and rd_addr are held stable while rd_ready=0.
  - On handshake: rd_valid drops next cycle.
  - If rd_addr was 2**AW−1, go to FIN. Otherwise memAddr+1, go to RADDR.
  - Throughput: one entry per RD_LAT+2 cycles with rd_ready held high.
- FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- `start` asserted on the same edge as the FIN→IDLE transition is ignored. A new `start` is accepted only from IDLE.
- mode never glitches high outside WRITE. memAddr wraps only via explicit reload, never by overflow into a write.

Optional Feature:
- Macro: POL_MEM_SWEEPER_SUM_EN.
- Defined:
  - Adds output `sum`, width DW+AW, signed.
  - Cleared on an accepted `start`.
  - Each handshake adds sign-extended rd_data.
  - Final value is valid from the `done` pulse until the next accepted `start`.
  - Reset clears it.
- Undefined: no `sum` port and no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset mid-WRITE (memAddr=5): all outputs go to 0 asynchronously before the next edge. After release, state is IDLE and busy=0.
- start with op=0, arg=01, rd_ready=1, memory model returns 3×addr on read:
  - 16 consecutive mode=1 cycles with memAddr 0..15, memOp=0, memArg=01.
  - Then 16 outputs: rd_addr=k, rd_data=3k.
  - done pulses once; total cycles from start = 16 + 16×(RD_LAT+2) + 1.
- Backpressure, rd_ready=0 for 5 cycles at rd_addr=7: rd_valid=1 and rd_data=21 are held stable. memAddr does not advance to 8 until the handshake.
- start pulsed during WRITE and during OUT: no restart, memOp/memArg unchanged, exactly one done pulse.
- With POL_MEM_SWEEPER_SUM_EN and a memory model returning −addr (9-bit two's complement): sum = −120 (13'h1F88) at done.
- RD_LAT=3 build: rd_data equals the model value for each address. Read spacing is 5 cycles per entry.
